// File: rtl/sda_kernel_control_regs_pkg.sv
`default_nettype none
// ============================================================================
// Module   : sda_kernel_control_regs_pkg
// Brief    : Register offsets, bit positions and response codes shared by the
//            kernel control register block and its AXI4-Lite front end.
// Revision : 1.0 - initial release
// ============================================================================
package sda_kernel_control_regs_pkg;

    localparam int c_ADDR_CTRL = 'h00;
    localparam int c_ADDR_GIE  = 'h04;
    localparam int c_ADDR_IER  = 'h08;
    localparam int c_ADDR_ISR  = 'h0C;

    localparam int c_ISR_DONE  = 0;
    localparam int c_ISR_READY = 1;

    localparam logic [1:0] c_RESP_OKAY = 2'b00;

    // CTRL register read image, MSB first
    typedef struct packed {
        logic apReady;
        logic apIdle;
        logic apDone;
        logic apStart;
    } ctrl_bits_t;

endpackage
`default_nettype wire

// File: rtl/sda_axi_lite_slave_if.sv
`default_nettype none
// ============================================================================
// Module   : sda_axi_lite_slave_if
// Brief    : AXI4-Lite slave channel handling; turns bus transactions into
//            single-cycle register write and read strobes.
// Revision : 1.0 - initial release
// ============================================================================
module sda_axi_lite_slave_if
    import sda_kernel_control_regs_pkg::*;
#(
    parameter int AddrWidth = 6,
    parameter int DataWidth = 32
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   s_axi_awvalid,
    output logic                   s_axi_awready,
    input  logic [AddrWidth-1:0]   s_axi_awaddr,
    input  logic                   s_axi_wvalid,
    output logic                   s_axi_wready,
    input  logic [DataWidth-1:0]   s_axi_wdata,
    input  logic [DataWidth/8-1:0] s_axi_wstrb,
    output logic                   s_axi_bvalid,
    input  logic                   s_axi_bready,
    output logic [1:0]             s_axi_bresp,
    input  logic                   s_axi_arvalid,
    output logic                   s_axi_arready,
    input  logic [AddrWidth-1:0]   s_axi_araddr,
    output logic                   s_axi_rvalid,
    input  logic                   s_axi_rready,
    output logic [DataWidth-1:0]   s_axi_rdata,
    output logic [1:0]             s_axi_rresp,
    output logic                   o_wrEn,
    output logic [AddrWidth-1:0]   o_wrAddr,
    output logic [DataWidth-1:0]   o_wrData,
    output logic                   o_rdEn,
    output logic [AddrWidth-1:0]   o_rdAddr,
    input  logic [DataWidth-1:0]   i_rdData
);

    logic                 r_outOfReset;
    logic                 r_awHeld;
    logic                 r_wHeld;
    logic [AddrWidth-1:0] r_awAddr;
    logic [DataWidth-1:0] r_wData;
    logic                 r_wStrb0;
    logic                 r_bValid;
    logic                 r_arHeld;
    logic [AddrWidth-1:0] r_arAddr;
    logic                 r_rValid;
    logic [DataWidth-1:0] r_rData;

    logic w_awFire;
    logic w_wFire;
    logic w_arFire;
    logic w_wrCommit;
    logic w_unused;

    // Ready outputs stay low while reset is applied and on the first cycle after
    assign s_axi_awready = r_outOfReset & ~r_awHeld & ~r_bValid;
    assign s_axi_wready  = r_outOfReset & ~r_wHeld  & ~r_bValid;
    assign s_axi_arready = r_outOfReset & ~r_rValid & ~r_arHeld;

    assign w_awFire   = s_axi_awvalid & s_axi_awready;
    assign w_wFire    = s_axi_wvalid  & s_axi_wready;
    assign w_arFire   = s_axi_arvalid & s_axi_arready;
    assign w_wrCommit = r_awHeld & r_wHeld;

    assign s_axi_bvalid = r_bValid;
    assign s_axi_bresp  = c_RESP_OKAY;
    assign s_axi_rvalid = r_rValid;
    assign s_axi_rdata  = r_rData;
    assign s_axi_rresp  = c_RESP_OKAY;

    assign o_wrEn   = w_wrCommit & r_wStrb0;
    assign o_wrAddr = r_awAddr;
    assign o_wrData = r_wData;
    assign o_rdEn   = r_arHeld;
    assign o_rdAddr = r_arAddr;

    assign w_unused = ^s_axi_wstrb;

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_outOfReset <= 1'b0;
            r_awHeld     <= 1'b0;
            r_wHeld      <= 1'b0;
            r_awAddr     <= '0;
            r_wData      <= '0;
            r_wStrb0     <= 1'b0;
            r_bValid     <= 1'b0;
            r_arHeld     <= 1'b0;
            r_arAddr     <= '0;
            r_rValid     <= 1'b0;
            r_rData      <= '0;
        end else begin
            r_outOfReset <= 1'b1;

            if (w_awFire) begin
                r_awHeld <= 1'b1;
                r_awAddr <= s_axi_awaddr;
            end else if (w_wrCommit) begin
                r_awHeld <= 1'b0;
            end

            if (w_wFire) begin
                r_wHeld  <= 1'b1;
                r_wData  <= s_axi_wdata;
                r_wStrb0 <= s_axi_wstrb[0];
            end else if (w_wrCommit) begin
                r_wHeld <= 1'b0;
            end

            if (w_wrCommit) begin
                r_bValid <= 1'b1;
            end else if (s_axi_bready) begin
                r_bValid <= 1'b0;
            end

            if (w_arFire) begin
                r_arHeld <= 1'b1;
                r_arAddr <= s_axi_araddr;
            end else begin
                r_arHeld <= 1'b0;
            end

            if (r_arHeld) begin
                r_rValid <= 1'b1;
                r_rData  <= i_rdData;
            end else if (s_axi_rready) begin
                r_rValid <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/sda_kernel_control_regs.sv
`default_nettype none
// ============================================================================
// Module   : sda_kernel_control_regs
// Brief    : ap_ctrl style kernel control registers with go/done handshakes
//            toward the kernel reset handler and a level interrupt.
// Revision : 1.0 - initial release
// ============================================================================
module sda_kernel_control_regs
    import sda_kernel_control_regs_pkg::*;
#(
    parameter int AddrWidth = 6,
    parameter int DataWidth = 32
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   s_axi_awvalid,
    output logic                   s_axi_awready,
    input  logic [AddrWidth-1:0]   s_axi_awaddr,
    input  logic                   s_axi_wvalid,
    output logic                   s_axi_wready,
    input  logic [DataWidth-1:0]   s_axi_wdata,
    input  logic [DataWidth/8-1:0] s_axi_wstrb,
    output logic                   s_axi_bvalid,
    input  logic                   s_axi_bready,
    output logic [1:0]             s_axi_bresp,
    input  logic                   s_axi_arvalid,
    output logic                   s_axi_arready,
    input  logic [AddrWidth-1:0]   s_axi_araddr,
    output logic                   s_axi_rvalid,
    input  logic                   s_axi_rready,
    output logic [DataWidth-1:0]   s_axi_rdata,
    output logic [1:0]             s_axi_rresp,
    output logic                   regGoValid,
    input  logic                   regGoHoldoff,
    input  logic                   regDoneValid,
    output logic                   regDoneStop,
    output logic                   interrupt
);

    logic                 w_wrEn;
    logic [AddrWidth-1:0] w_wrAddr;
    logic [DataWidth-1:0] w_wrData;
    logic                 w_rdEn;
    logic [AddrWidth-1:0] w_rdAddr;
    logic [DataWidth-1:0] w_rdData;

    logic       r_apStart;
    logic       r_apDone;
    logic       r_apReady;
    logic       r_busy;
    logic       r_gie;
    logic [1:0] r_ier;
    logic [1:0] r_isr;
    logic       r_interrupt;

    logic       w_goXfer;
    logic       w_doneXfer;
    logic       w_wrCtrl;
    logic       w_wrGie;
    logic       w_wrIer;
    logic       w_wrIsr;
    logic       w_rdCtrl;
    ctrl_bits_t w_ctrl;
    logic       w_unused;

    function automatic logic addrHit(input logic [AddrWidth-1:0] addr, input int offset);
        return (addr >> 2) == AddrWidth'(offset >> 2);
    endfunction

    sda_axi_lite_slave_if #(
        .AddrWidth (AddrWidth),
        .DataWidth (DataWidth)
    ) u_axiIf (
        .clk           (clk),
        .srst          (srst),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .o_wrEn        (w_wrEn),
        .o_wrAddr      (w_wrAddr),
        .o_wrData      (w_wrData),
        .o_rdEn        (w_rdEn),
        .o_rdAddr      (w_rdAddr),
        .i_rdData      (w_rdData)
    );

    assign regGoValid  = r_apStart;
    assign regDoneStop = ~r_busy;
    assign interrupt   = r_interrupt;

    assign w_goXfer   = r_apStart & ~regGoHoldoff;
    assign w_doneXfer = regDoneValid & r_busy;

    assign w_wrCtrl = w_wrEn & addrHit(w_wrAddr, c_ADDR_CTRL);
    assign w_wrGie  = w_wrEn & addrHit(w_wrAddr, c_ADDR_GIE);
    assign w_wrIer  = w_wrEn & addrHit(w_wrAddr, c_ADDR_IER);
    assign w_wrIsr  = w_wrEn & addrHit(w_wrAddr, c_ADDR_ISR);
    assign w_rdCtrl = w_rdEn & addrHit(w_rdAddr, c_ADDR_CTRL);

    assign w_ctrl.apReady = r_apReady;
    assign w_ctrl.apIdle  = ~r_busy & ~r_apStart;
    assign w_ctrl.apDone  = r_apDone;
    assign w_ctrl.apStart = r_apStart;

    assign w_unused = ^w_wrData[DataWidth-1:2];

    always_comb begin
        w_rdData = '0;
        if (addrHit(w_rdAddr, c_ADDR_CTRL)) begin
            w_rdData[3:0] = w_ctrl;
        end else if (addrHit(w_rdAddr, c_ADDR_GIE)) begin
            w_rdData[0] = r_gie;
        end else if (addrHit(w_rdAddr, c_ADDR_IER)) begin
            w_rdData[1:0] = r_ier;
        end else if (addrHit(w_rdAddr, c_ADDR_ISR)) begin
            w_rdData[1:0] = r_isr;
        end
    end

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_apStart   <= 1'b0;
            r_apDone    <= 1'b0;
            r_apReady   <= 1'b0;
            r_busy      <= 1'b0;
            r_gie       <= 1'b0;
            r_ier       <= 2'b00;
            r_isr       <= 2'b00;
            r_interrupt <= 1'b0;
        end else begin
            // A go transfer consumes the pending start; a start write landing
            // in the same cycle is the request just being served.
            if (w_goXfer) begin
                r_apStart <= 1'b0;
            end else if (w_wrCtrl && w_wrData[0]) begin
                r_apStart <= 1'b1;
            end

            if (w_goXfer) begin
                r_busy <= 1'b1;
            end else if (w_doneXfer) begin
                r_busy <= 1'b0;
            end

            r_apReady <= w_goXfer;

            if (w_doneXfer) begin
                r_apDone <= 1'b1;
            end else if (w_rdCtrl) begin
                r_apDone <= 1'b0;
            end

            if (w_doneXfer) begin
                r_isr[c_ISR_DONE] <= 1'b1;
            end else if (w_wrIsr && w_wrData[c_ISR_DONE]) begin
                r_isr[c_ISR_DONE] <= ~r_isr[c_ISR_DONE];
            end

            if (w_goXfer) begin
                r_isr[c_ISR_READY] <= 1'b1;
            end else if (w_wrIsr && w_wrData[c_ISR_READY]) begin
                r_isr[c_ISR_READY] <= ~r_isr[c_ISR_READY];
            end

            if (w_wrGie) begin
                r_gie <= w_wrData[0];
            end
            if (w_wrIer) begin
                r_ier <= w_wrData[1:0];
            end

            r_interrupt <= r_gie & |(r_isr & r_ier);
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_sda_kernel_control_regs.sv
`default_nettype none
// ============================================================================
// Module   : tb_sda_kernel_control_regs
// Brief    : Directed self-checking bench for the kernel control registers.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sda_kernel_control_regs;

    logic        clk = 1'b0;
    logic        srst;
    logic        s_axi_awvalid, s_axi_awready;
    logic [5:0]  s_axi_awaddr;
    logic        s_axi_wvalid, s_axi_wready;
    logic [31:0] s_axi_wdata;
    logic [3:0]  s_axi_wstrb;
    logic        s_axi_bvalid, s_axi_bready;
    logic [1:0]  s_axi_bresp;
    logic        s_axi_arvalid, s_axi_arready;
    logic [5:0]  s_axi_araddr;
    logic        s_axi_rvalid, s_axi_rready;
    logic [31:0] s_axi_rdata;
    logic [1:0]  s_axi_rresp;
    logic        regGoValid, regGoHoldoff, regDoneValid, regDoneStop, interrupt;

    int nChecks = 0;
    int nPass   = 0;

    typedef struct {
        bit          wr;
        logic [5:0]  addr;
        logic [31:0] data;
        logic [3:0]  strb;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [0:24];

    always #5 clk = ~clk;

    sda_kernel_control_regs #(.AddrWidth(6), .DataWidth(32)) dut (
        .clk           (clk),
        .srst          (srst),
        .s_axi_awvalid (s_axi_awvalid),
        .s_axi_awready (s_axi_awready),
        .s_axi_awaddr  (s_axi_awaddr),
        .s_axi_wvalid  (s_axi_wvalid),
        .s_axi_wready  (s_axi_wready),
        .s_axi_wdata   (s_axi_wdata),
        .s_axi_wstrb   (s_axi_wstrb),
        .s_axi_bvalid  (s_axi_bvalid),
        .s_axi_bready  (s_axi_bready),
        .s_axi_bresp   (s_axi_bresp),
        .s_axi_arvalid (s_axi_arvalid),
        .s_axi_arready (s_axi_arready),
        .s_axi_araddr  (s_axi_araddr),
        .s_axi_rvalid  (s_axi_rvalid),
        .s_axi_rready  (s_axi_rready),
        .s_axi_rdata   (s_axi_rdata),
        .s_axi_rresp   (s_axi_rresp),
        .regGoValid    (regGoValid),
        .regGoHoldoff  (regGoHoldoff),
        .regDoneValid  (regDoneValid),
        .regDoneStop   (regDoneStop),
        .interrupt     (interrupt)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nChecks++;
        if (act === exp) nPass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic axiWrite(input logic [5:0] addr, input logic [31:0] data, input logic [3:0] strb);
        bit awGo, wGo, bGo, done;
        done = 1'b0;
        @(negedge clk);
        s_axi_awvalid = 1'b1; s_axi_awaddr = addr;
        s_axi_wvalid  = 1'b1; s_axi_wdata  = data; s_axi_wstrb = strb;
        s_axi_bready  = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            awGo = s_axi_awvalid & s_axi_awready;
            wGo  = s_axi_wvalid  & s_axi_wready;
            bGo  = s_axi_bvalid  & s_axi_bready;
            @(negedge clk);
            if (awGo) s_axi_awvalid = 1'b0;
            if (wGo)  s_axi_wvalid  = 1'b0;
            if (bGo)  done = 1'b1;
        end
        s_axi_awvalid = 1'b0; s_axi_wvalid = 1'b0; s_axi_bready = 1'b0;
        if (!done) check("write_timeout", 32'd0, 32'd1);
    endtask

    task automatic axiRead(input logic [5:0] addr, output logic [31:0] data);
        bit arGo, rGo, done;
        done = 1'b0;
        data = 'x;
        @(negedge clk);
        s_axi_arvalid = 1'b1; s_axi_araddr = addr; s_axi_rready = 1'b1;
        for (int c = 0; c < 50 && !done; c++) begin
            arGo = s_axi_arvalid & s_axi_arready;
            rGo  = s_axi_rvalid  & s_axi_rready;
            if (rGo) data = s_axi_rdata;
            @(negedge clk);
            if (arGo) s_axi_arvalid = 1'b0;
            if (rGo)  done = 1'b1;
        end
        s_axi_arvalid = 1'b0; s_axi_rready = 1'b0;
        if (!done) check("read_timeout", 32'd0, 32'd1);
    endtask

    task automatic readCheck(input string name, input logic [5:0] addr, input logic [31:0] exp);
        logic [31:0] d;
        axiRead(addr, d);
        check(name, d, exp);
    endtask

    initial begin
        logic [31:0] d;
        int nXfer;

        tbl[0]  = '{0, 6'h00, 32'h0,        4'h0, 32'h4};
        tbl[1]  = '{0, 6'h04, 32'h0,        4'h0, 32'h0};
        tbl[2]  = '{0, 6'h08, 32'h0,        4'h0, 32'h0};
        tbl[3]  = '{0, 6'h0C, 32'h0,        4'h0, 32'h0};
        tbl[4]  = '{1, 6'h04, 32'hFFFFFFFF, 4'hF, 32'h0};
        tbl[5]  = '{0, 6'h04, 32'h0,        4'h0, 32'h1};
        tbl[6]  = '{1, 6'h08, 32'hFFFFFFFF, 4'hF, 32'h0};
        tbl[7]  = '{0, 6'h08, 32'h0,        4'h0, 32'h3};
        tbl[8]  = '{1, 6'h08, 32'h0,        4'hE, 32'h0};
        tbl[9]  = '{0, 6'h08, 32'h0,        4'h0, 32'h3};
        tbl[10] = '{1, 6'h08, 32'h0,        4'hF, 32'h0};
        tbl[11] = '{0, 6'h08, 32'h0,        4'h0, 32'h0};
        tbl[12] = '{1, 6'h04, 32'h0,        4'hF, 32'h0};
        tbl[13] = '{0, 6'h04, 32'h0,        4'h0, 32'h0};
        tbl[14] = '{1, 6'h10, 32'hDEADBEEF, 4'hF, 32'h0};
        tbl[15] = '{0, 6'h10, 32'h0,        4'h0, 32'h0};
        tbl[16] = '{1, 6'h0C, 32'h3,        4'hF, 32'h0};
        tbl[17] = '{0, 6'h0C, 32'h0,        4'h0, 32'h3};
        tbl[18] = '{1, 6'h0C, 32'h1,        4'hF, 32'h0};
        tbl[19] = '{0, 6'h0C, 32'h0,        4'h0, 32'h2};
        tbl[20] = '{1, 6'h0C, 32'h2,        4'hF, 32'h0};
        tbl[21] = '{0, 6'h0C, 32'h0,        4'h0, 32'h0};
        tbl[22] = '{1, 6'h00, 32'hE,        4'hF, 32'h0};
        tbl[23] = '{0, 6'h00, 32'h0,        4'h0, 32'h4};
        tbl[24] = '{0, 6'h3C, 32'h0,        4'h0, 32'h0};

        srst = 1'b1;
        s_axi_awvalid = 0; s_axi_awaddr = 0; s_axi_wvalid = 0; s_axi_wdata = 0;
        s_axi_wstrb = 0; s_axi_bready = 0; s_axi_arvalid = 0; s_axi_araddr = 0;
        s_axi_rready = 0; regGoHoldoff = 1'b1; regDoneValid = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_awready", {31'b0, s_axi_awready}, 0);
        check("rst_arready", {31'b0, s_axi_arready}, 0);
        check("rst_bvalid",  {31'b0, s_axi_bvalid}, 0);
        check("rst_rvalid",  {31'b0, s_axi_rvalid}, 0);
        check("rst_rdata",   s_axi_rdata, 0);
        check("rst_goValid", {31'b0, regGoValid}, 0);
        check("rst_doneStop", {31'b0, regDoneStop}, 1);
        check("rst_irq",     {31'b0, interrupt}, 0);
        srst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 25; i++) begin
            if (tbl[i].wr) begin
                axiWrite(tbl[i].addr, tbl[i].data, tbl[i].strb);
            end else begin
                axiRead(tbl[i].addr, d);
                check($sformatf("tbl%0d_rd_%02h", i, tbl[i].addr), d, tbl[i].exp);
            end
        end
        check("tbl_irq", {31'b0, interrupt}, 0);
        check("tbl_goValid", {31'b0, regGoValid}, 0);

        // Start with holdoff: regGoValid stays up until holdoff drops
        axiWrite(6'h00, 32'h1, 4'hF);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("go_held%0d", i), {31'b0, regGoValid}, 1);
            @(negedge clk);
        end
        regGoHoldoff = 1'b0;
        check("go_last", {31'b0, regGoValid}, 1);
        @(negedge clk);
        regGoHoldoff = 1'b1;
        check("go_dropped", {31'b0, regGoValid}, 0);
        check("busy_doneStop", {31'b0, regDoneStop}, 0);
        readCheck("ctrl_busy", 6'h00, 32'h0);
        readCheck("isr_ready", 6'h0C, 32'h2);

        // Done held three cycles must transfer exactly once
        regDoneValid = 1'b1;
        nXfer = 0;
        for (int i = 0; i < 3; i++) begin
            if (regDoneValid && !regDoneStop) nXfer++;
            @(negedge clk);
        end
        regDoneValid = 1'b0;
        check("done_xfers", nXfer, 1);
        readCheck("ctrl_done", 6'h00, 32'h6);
        readCheck("ctrl_cor",  6'h00, 32'h4);
        readCheck("isr_both",  6'h0C, 32'h3);
        axiWrite(6'h0C, 32'h3, 4'hF);
        readCheck("isr_clr",   6'h0C, 32'h0);

        // Interrupt on done
        axiWrite(6'h04, 32'h1, 4'hF);
        axiWrite(6'h08, 32'h1, 4'hF);
        regGoHoldoff = 1'b0;
        axiWrite(6'h00, 32'h1, 4'hF);
        regGoHoldoff = 1'b1;
        check("irq_run_busy", {31'b0, regDoneStop}, 0);
        check("irq_masked_ready", {31'b0, interrupt}, 0);
        regDoneValid = 1'b1;
        @(negedge clk);
        regDoneValid = 1'b0;
        @(negedge clk);
        check("irq_set", {31'b0, interrupt}, 1);
        axiWrite(6'h0C, 32'h1, 4'hF);
        check("irq_clr", {31'b0, interrupt}, 0);
        readCheck("irq_isr", 6'h0C, 32'h2);
        axiWrite(6'h0C, 32'h2, 4'hF);
        axiWrite(6'h04, 32'h0, 4'hF);
        axiWrite(6'h08, 32'h0, 4'hF);
        readCheck("irq_ctrl", 6'h00, 32'h6);

        // Split AW/W with stalled bready
        @(negedge clk);
        s_axi_awvalid = 1'b1; s_axi_awaddr = 6'h08;
        check("split_awready", {31'b0, s_axi_awready}, 1);
        @(negedge clk);
        s_axi_awvalid = 1'b0;
        repeat (2) @(negedge clk);
        check("split_aw_held", {31'b0, s_axi_awready}, 0);
        check("split_no_b", {31'b0, s_axi_bvalid}, 0);
        s_axi_wvalid = 1'b1; s_axi_wdata = 32'h3; s_axi_wstrb = 4'hF; s_axi_bready = 1'b0;
        check("split_wready", {31'b0, s_axi_wready}, 1);
        @(negedge clk);
        s_axi_wvalid = 1'b0;
        @(negedge clk);
        check("split_bvalid", {31'b0, s_axi_bvalid}, 1);
        check("split_bresp", {30'b0, s_axi_bresp}, 0);
        @(negedge clk);
        check("split_bhold1", {31'b0, s_axi_bvalid}, 1);
        check("split_awblock", {31'b0, s_axi_awready}, 0);
        @(negedge clk);
        check("split_bhold2", {31'b0, s_axi_bvalid}, 1);
        s_axi_bready = 1'b1;
        @(negedge clk);
        s_axi_bready = 1'b0;
        check("split_bdone", {31'b0, s_axi_bvalid}, 0);
        readCheck("split_ier", 6'h08, 32'h3);
        axiWrite(6'h08, 32'h0, 4'hF);

        // Done lands on the CTRL read capture cycle: set wins over clear
        regGoHoldoff = 1'b0;
        axiWrite(6'h00, 32'h1, 4'hF);
        regGoHoldoff = 1'b1;
        @(negedge clk);
        s_axi_arvalid = 1'b1; s_axi_araddr = 6'h00; s_axi_rready = 1'b0;
        check("race_arready", {31'b0, s_axi_arready}, 1);
        @(negedge clk);
        s_axi_arvalid = 1'b0;
        regDoneValid = 1'b1;
        @(negedge clk);
        regDoneValid = 1'b0;
        check("race_rvalid", {31'b0, s_axi_rvalid}, 1);
        check("race_rdata", s_axi_rdata, 32'h0);
        s_axi_rready = 1'b1;
        @(negedge clk);
        s_axi_rready = 1'b0;
        check("race_rdone", {31'b0, s_axi_rvalid}, 0);
        readCheck("race_done_kept", 6'h00, 32'h6);
        readCheck("race_done_cor",  6'h00, 32'h4);

        // Reset while a start is pending
        axiWrite(6'h00, 32'h1, 4'hF);
        check("mid_goValid", {31'b0, regGoValid}, 1);
        srst = 1'b1;
        #1;
        check("mid_rst_go", {31'b0, regGoValid}, 0);
        @(negedge clk);
        srst = 1'b0;
        readCheck("mid_rst_ctrl", 6'h00, 32'h4);
        readCheck("mid_rst_isr",  6'h0C, 32'h0);

        $display("%0d/%0d checks passed", nPass, nChecks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/sda_kernel_control_regs.md
Name: sda_kernel_control_regs

Overview:
- Host-facing AXI4-Lite control register block that initiates kernel runs and collects their completion.
- Drives the go request and consumes the done notification of the kernel reset handler; it is the register-side end of the go/done valid/holdoff and valid/stop handshakes.
- Exposes the SDAccel-style ap_ctrl register set (start/done/idle/ready) with global, per-source and status interrupt registers, plus a level interrupt output.

Parameters:
AddrWidth, 6, AXI4-Lite address width; only addr[AddrWidth-1:2] decoded (word aligned)
DataWidth, 32, AXI4-Lite data width; fixed, other values unsupported

Ports:
clk  in  1  system clock
srst  in  1  reset, asynchronous assert, active-high; synchronously deasserted externally
s_axi_awvalid/s_axi_awready  in/out  1  write address handshake
s_axi_awaddr  in  AddrWidth  write address
s_axi_wvalid/s_axi_wready  in/out  1  write data handshake
s_axi_wdata  in  32  write data
s_axi_wstrb  in  4  byte strobes; write applies only if wstrb[0]=1
s_axi_bvalid/s_axi_bready  out/in  1  write response handshake
s_axi_bresp  out  2  always 2'b00 (OKAY)
s_axi_arvalid/s_axi_arready  in/out  1  read address handshake
s_axi_araddr  in  AddrWidth  read address
s_axi_rvalid/s_axi_rready  out/in  1  read data handshake
s_axi_rdata  out  32  read data
s_axi_rresp  out  2  always 2'b00
regGoValid  out  1  go request to reset handler
regGoHoldoff  in  1  go transfer occurs on regGoValid & ~regGoHoldoff
regDoneValid  in  1  done notification from reset handler
regDoneStop  out  1  done transfer occurs on regDoneValid & ~regDoneStop
interrupt  out  1  registered level interrupt

Behaviour:
- Reset values: all awready/wready/arready/bvalid/rvalid/rdata 0; regGoValid 0; regDoneStop 1; interrupt 0; ap_start, ap_done, busy, GIE, IER, ISR all 0.
- Register map (byte offsets): 0x00 CTRL {bit0 ap_start RW, bit1 ap_done R/COR, bit2 ap_idle R, bit3 ap_ready R}; 0x04 GIE bit0; 0x08 IER bits[1:0] {ready, done}; 0x0C ISR bits[1:0], write-1-toggle; others read 0, writes ignored, OKAY response.
- Write channel: AW and W accepted independently; awready = ~awHeld & ~bvalid, same for wready. Each latched into its holding reg. Cycle after both held: register update, bvalid=1, holds cleared. bvalid held until bready. One outstanding write max.
- Read channel: arready = ~rvalid & ~arHeld. Accept -> next cycle rdata registered, rvalid=1; held stable until rready. Read of 0x00 clears ap_done on the accepting cycle of rdata capture.
- ap_start: set by write of 1 to CTRL bit0; write of 0 ignored. Cleared only by go transfer. regGoValid = ap_start.
- Go transfer (regGoValid & ~regGoHoldoff): ap_start<=0, busy<=1, ap_ready pulses 1 cycle, ISR[1]<=1.
- regDoneStop = ~busy. Done transfer (regDoneValid & ~regDoneStop): busy<=0, ap_done<=1, ISR[0]<=1.
- ap_idle = ~busy & ~ap_start (combinational in read mux).
- Simultaneous: done set vs CTRL read clear -> set wins (ap_done stays 1). ISR event set vs host toggle same bit -> set wins. ap_start write while busy -> accepted, go issued after current done and handler re-idles.
- interrupt registered: GIE & |(ISR & IER); 1 cycle after source change.
- Reset mid-run: all state cleared immediately; pending AXI transactions dropped.

Decomposition:
- Shared package: register offsets, CTRL/ISR bit indices, BRESP/RRESP OKAY constant.
- Sub-module sda_axi_lite_slave_if: AXI4-Lite channel handshakes, emits wrEn/wrAddr/wrData and rdEn/rdAddr, accepts rdData; top keeps ap_ctrl logic.

Test Plan:
- Reset, read 0x00 -> rdata 0x00000004 (idle), interrupt 0, regDoneStop 1.
- Write 0x00=0x1, regGoHoldoff=1 for 3 cycles then 0 -> regGoValid high 4 cycles, then 0; CTRL reads 0x0 while busy.
- regDoneValid=1 while busy -> 1 transfer, CTRL reads 0x6, second read 0x4.
- GIE=1, IER=0x1, run kernel -> interrupt 1 after done; write ISR=0x1 -> interrupt 0 next cycle.
- AW presented 3 cycles before W, bready low 2 cycles -> single write, bvalid held, bresp 0.
- regDoneValid coincides with CTRL read rdata capture -> ap_done remains 1 on following read.
